// File: rtl/smg_scan_decoder.sv
// Scanned 7-segment bus decoder: recovers four digit values from a multiplexed display.
// Define SMG_DECODE_HEX_EN to also decode A,b,C,d,E,F as 10..15.
module smg_scan_decoder #(
    parameter int SETTLE_CYC  = 8,
    parameter int MATCH_CNT   = 2,
    parameter int TIMEOUT_CYC = 24000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dig,
    input  logic [7:0] smg,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] dp,
    output logic [3:0] blank,
    output logic [3:0] err,
    output logic       upd,
    output logic       frame_valid,
    output logic       idle
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int MW = $clog2(MATCH_CNT + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [3:0]    r_dig_s1, r_dig_s2;
    logic [7:0]    r_smg_s1, r_smg_s2;
    logic [11:0]   r_last;
    logic [SW-1:0] r_settle;
    logic [7:0]    r_cand [4];
    logic [MW-1:0] r_mcnt [4];
    logic          r_acc_stb;
    logic [1:0]    r_acc_idx;
    logic [7:0]    r_acc_smg;
    logic [3:0]    r_acc;
    logic [TW-1:0] r_idle_cnt;
    logic [3:0]    r_d [4];

    logic          w_chg, w_valid, w_cap, w_same, w_diff;
    logic [1:0]    w_idx;
    logic [MW-1:0] w_mnext;
    logic [6:0]    w_lit;
    logic [4:0]    w_dec;
    logic [3:0]    w_nd, w_acc_set;
    logic          w_ndp, w_nblank, w_nerr;

    // Returns {recognised, value} for an active-high g..a segment pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] lit);
        logic [4:0] r;
        case (lit)
            7'h3F:   r = {1'b1, 4'd0};
            7'h06:   r = {1'b1, 4'd1};
            7'h5B:   r = {1'b1, 4'd2};
            7'h4F:   r = {1'b1, 4'd3};
            7'h66:   r = {1'b1, 4'd4};
            7'h6D:   r = {1'b1, 4'd5};
            7'h7D:   r = {1'b1, 4'd6};
            7'h07:   r = {1'b1, 4'd7};
            7'h7F:   r = {1'b1, 4'd8};
            7'h6F:   r = {1'b1, 4'd9};
`ifdef SMG_DECODE_HEX_EN
            7'h77:   r = {1'b1, 4'd10};
            7'h7C:   r = {1'b1, 4'd11};
            7'h39:   r = {1'b1, 4'd12};
            7'h5E:   r = {1'b1, 4'd13};
            7'h79:   r = {1'b1, 4'd14};
            7'h71:   r = {1'b1, 4'd15};
`endif
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    assign d0 = r_d[0];
    assign d1 = r_d[1];
    assign d2 = r_d[2];
    assign d3 = r_d[3];

    assign w_chg = {r_dig_s2, r_smg_s2} != r_last;

    always_comb begin
        w_valid = 1'b1;
        w_idx   = 2'd0;
        case (r_dig_s2)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_valid = 1'b0;
        endcase
    end

    // r_settle counts cycles the value has been held; capture fires once on reaching SETTLE_CYC.
    assign w_cap  = w_valid && !w_chg && (r_settle == SW'(SETTLE_CYC - 1));
    assign w_same = (r_smg_s2 == r_cand[w_idx]) && (r_mcnt[w_idx] != '0);

    always_comb begin
        w_mnext = MW'(1);
        if (w_same)
            w_mnext = (r_mcnt[w_idx] == MW'(MATCH_CNT)) ? r_mcnt[w_idx]
                                                       : r_mcnt[w_idx] + MW'(1);
    end

    assign w_lit     = ~r_acc_smg[6:0];
    assign w_dec     = seg_decode(w_lit);
    assign w_acc_set = r_acc_stb ? (4'b0001 << r_acc_idx) : 4'b0000;

    always_comb begin
        w_nd     = r_d[r_acc_idx];
        w_nerr   = err[r_acc_idx];
        w_nblank = 1'b0;
        w_ndp    = ~r_acc_smg[7];
        if (w_lit == 7'h00)
            w_nblank = 1'b1;
        else if (w_dec[4]) begin
            w_nd   = w_dec[3:0];
            w_nerr = 1'b0;
        end else
            w_nerr = 1'b1;
        w_diff = (w_nd != r_d[r_acc_idx]) || (w_ndp != dp[r_acc_idx]) ||
                 (w_nblank != blank[r_acc_idx]) || (w_nerr != err[r_acc_idx]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dig_s1    <= '0;
            r_dig_s2    <= '0;
            r_smg_s1    <= '0;
            r_smg_s2    <= '0;
            r_last      <= '0;
            r_settle    <= '0;
            r_acc_stb   <= 1'b0;
            r_acc_idx   <= '0;
            r_acc_smg   <= '0;
            r_acc       <= '0;
            r_idle_cnt  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cand[i] <= '0;
                r_mcnt[i] <= '0;
                r_d[i]    <= '0;
            end
            dp          <= '0;
            blank       <= 4'hF;
            err         <= '0;
            upd         <= 1'b0;
            frame_valid <= 1'b0;
            idle        <= 1'b1;
        end else begin
            r_dig_s1 <= dig;
            r_dig_s2 <= r_dig_s1;
            r_smg_s1 <= smg;
            r_smg_s2 <= r_smg_s1;
            r_last   <= {r_dig_s2, r_smg_s2};

            if (w_chg)
                r_settle <= SW'(1);
            else if (r_settle != SW'(SETTLE_CYC))
                r_settle <= r_settle + SW'(1);

            r_acc_stb <= w_cap && (w_mnext == MW'(MATCH_CNT));
            r_acc_idx <= w_idx;
            r_acc_smg <= r_smg_s2;
            if (w_cap) begin
                r_cand[w_idx] <= r_smg_s2;
                r_mcnt[w_idx] <= w_mnext;
            end

            upd         <= 1'b0;
            frame_valid <= 1'b0;
            if (r_acc_stb) begin
                r_d[r_acc_idx]   <= w_nd;
                dp[r_acc_idx]    <= w_ndp;
                blank[r_acc_idx] <= w_nblank;
                err[r_acc_idx]   <= w_nerr;
                upd              <= w_diff;
            end
            if (r_acc == 4'hF) begin
                frame_valid <= 1'b1;
                r_acc       <= w_acc_set;
            end else
                r_acc <= r_acc | w_acc_set;

            if (w_cap) begin
                r_idle_cnt <= '0;
                idle       <= 1'b0;
            end else if (r_idle_cnt != TW'(TIMEOUT_CYC)) begin
                r_idle_cnt <= r_idle_cnt + TW'(1);
                if (r_idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    idle  <= 1'b1;
                    r_acc <= '0;
                    for (int i = 0; i < 4; i++)
                        r_mcnt[i] <= '0;
                end
            end
        end
    end
endmodule
